// File: rtl/addr_sweep_pkg.sv
// rtl/addr_sweep_pkg.sv - shared state type and default sizing for the address sweep generator
package addr_sweep_pkg;

    // Default geometry: 2 lanes of 14-bit addresses sweeping index 4352..4479.
    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_LANES     = 2;
    localparam int DEF_IDX_START = 4352;
    localparam int DEF_IDX_END   = 4479;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/sweep_idx_ctr.sv
// rtl/sweep_idx_ctr.sv - sweep index register with end-of-range compare
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset; loads IDX_START
//   clear    reload IDX_START next cycle (takes priority over advance)
//   advance  increment the index by one next cycle
//   idx      current sweep index
//   at_end   idx equals IDX_END
module sweep_idx_ctr
    import addr_sweep_pkg::*;
#(
    parameter int IDX_W     = DEF_ADDR_W - 1,
    parameter int IDX_START = DEF_IDX_START,
    parameter int IDX_END   = DEF_IDX_END
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic             at_end
);

    localparam logic [IDX_W-1:0] START_V = IDX_W'(IDX_START);
    localparam logic [IDX_W-1:0] END_V   = IDX_W'(IDX_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= START_V;
        end else if (clear) begin
            idx <= START_V;
        end else if (advance) begin
            idx <= idx + IDX_W'(1);
        end
    end

    assign at_end = (idx == END_V);

endmodule

// File: rtl/addr_sweep_gen.sv
// rtl/addr_sweep_gen.sv - multi-lane interleaved address sweep generator
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      begin a sweep (looked at in IDLE only)
//   abort      terminate the sweep (looked at in RUN only)
//   mode_wrap  1 = restart at IDX_START after IDX_END, 0 = one-shot
//   ready      consumer accepts the current beat
//   addr       LANES packed addresses, lane i = {idx, i}
//   valid      addr holds a beat
//   busy       sweep in progress
//   done       one-cycle pulse when a sweep completes
//
// Build option: ADDR_SWEEP_WRAP_EN enables continuous (wrapping) sweeps;
// without it mode_wrap is ignored and every sweep is one-shot.
module addr_sweep_gen
    import addr_sweep_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LANES     = DEF_LANES,
    parameter int IDX_START = DEF_IDX_START,
    parameter int IDX_END   = DEF_IDX_END
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    mode_wrap,
    input  logic                    ready,
    output logic [LANES*ADDR_W-1:0] addr,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = ADDR_W - LANE_W;

    sweep_state_t     state;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic [IDX_W-1:0] idx;
    logic             at_end;
    logic             wrap_sel;
    logic             xfer;
    logic             final_xfer;
    logic             ctr_clear;
    logic             ctr_adv;

`ifdef ADDR_SWEEP_WRAP_EN
    assign wrap_sel = mode_wrap;
`else
    logic unused_mode_wrap;
    assign unused_mode_wrap = mode_wrap;
    assign wrap_sel         = 1'b0;
`endif

    assign xfer       = (state == ST_RUN) && ready;
    assign final_xfer = xfer && at_end;

    // Abort wins over everything in RUN; the index returns to IDX_START both
    // on abort and on the last beat (wrap or one-shot), so IDLE always
    // presents IDX_START.
    assign ctr_clear = (state == ST_RUN) && (abort || final_xfer);
    assign ctr_adv   = (state == ST_RUN) && !abort && xfer && !at_end;

    sweep_idx_ctr #(
        .IDX_W    (IDX_W),
        .IDX_START(IDX_START),
        .IDX_END  (IDX_END)
    ) u_idx_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clear),
        .advance(ctr_adv),
        .idx    (idx),
        .at_end (at_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (final_xfer) begin
                        done_q <= 1'b1;
                        if (!wrap_sel) begin
                            state   <= ST_IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Lanes share the index and differ only in the low LANE_W bits.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign addr[i*ADDR_W +: ADDR_W] = {idx, LANE_W'(i)};
    end

    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_addr_sweep_gen.sv
// tb/tb_addr_sweep_gen.sv - randomized model-checked bench for addr_sweep_gen
module tb_addr_sweep_gen;

    localparam int A_W = 14, A_L = 2, A_S = 4352, A_E = 4479;
    localparam int B_W = 16, B_L = 4, B_S = 10,   B_E = 12;
`ifdef ADDR_SWEEP_WRAP_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, abort = 1'b0, mode_wrap = 1'b0, ready = 1'b0;
    logic [A_L*A_W-1:0] addr_a;
    logic [B_L*B_W-1:0] addr_b;
    logic valid_a, busy_a, done_a, valid_b, busy_b, done_b;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    bit m_run  [2];
    int m_idx  [2];
    bit m_done [2];

    always #5 clk = ~clk;

    addr_sweep_gen dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mode_wrap(mode_wrap), .ready(ready), .addr(addr_a),
        .valid(valid_a), .busy(busy_a), .done(done_a)
    );

    addr_sweep_gen #(.ADDR_W(B_W), .LANES(B_L), .IDX_START(B_S), .IDX_END(B_E)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mode_wrap(mode_wrap), .ready(ready), .addr(addr_b),
        .valid(valid_b), .busy(busy_b), .done(done_b)
    );

    function automatic int st_of(input int k);
        return (k == 0) ? A_S : B_S;
    endfunction

    function automatic int en_of(input int k);
        return (k == 0) ? A_E : B_E;
    endfunction

    function automatic int lane_a(input int i);
        return int'(addr_a[i*A_W +: A_W]);
    endfunction

    function automatic int lane_b(input int i);
        return int'(addr_b[i*B_W +: B_W]);
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a sweep walks idx = START..END, one step per accepted beat.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_run[k]  <= 1'b0;
                m_idx[k]  <= st_of(k);
                m_done[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] <= 1'b0;
                if (!m_run[k]) begin
                    if (start) m_run[k] <= 1'b1;
                end else if (abort) begin
                    m_run[k] <= 1'b0;
                    m_idx[k] <= st_of(k);
                end else if (ready) begin
                    if (m_idx[k] == en_of(k)) begin
                        m_done[k] <= 1'b1;
                        m_idx[k]  <= st_of(k);
                        if (!(WRAP_ON && mode_wrap)) m_run[k] <= 1'b0;
                    end else begin
                        m_idx[k] <= m_idx[k] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_a", valid_a, m_run[0]);
            check("busy_a",  busy_a,  m_run[0]);
            check("done_a",  done_a,  m_done[0]);
            for (int i = 0; i < A_L; i++) check("addr_a", lane_a(i), m_idx[0]*A_L + i);
            check("valid_b", valid_b, m_run[1]);
            check("busy_b",  busy_b,  m_run[1]);
            check("done_b",  done_b,  m_done[1]);
            for (int i = 0; i < B_L; i++) check("addr_b", lane_b(i), m_idx[1]*B_L + i);
        end
    end

    task automatic wait_a(input int v, input string nm);
        int c;
        c = 0;
        while (!(valid_a && lane_a(0) == v)) begin
            if (c >= 600) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: timeout, lane0 %0d expected %0d", nm, lane_a(0), v);
                return;
            end
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        int n, c, l0, l1;
        #1 reset = 1'b0;
        #2;
        check("rst_addr0", lane_a(0), 8704);
        check("rst_addr1", lane_a(1), 8705);
        check("rst_valid", valid_a, 0);
        check("rst_done", done_a, 0);
        check("rst_b_addr0", lane_b(0), 40);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Full one-shot sweep with ready held high.
        ready = 1'b1; mode_wrap = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_beat0", lane_a(0), 8704);
        check("first_beat1", lane_a(1), 8705);
        n = 0; c = 0; l0 = 0; l1 = 0;
        while (!done_a && c < 400) begin
            if (c == 0) begin
                check("b_beat0_l0", lane_b(0), 40);
                check("b_beat0_l3", lane_b(3), 43);
            end
            if (c == 1) check("b_beat1_l0", lane_b(0), 44);
            if (c == 2) begin
                check("b_beat2_l0", lane_b(0), 48);
                check("b_beat2_l3", lane_b(3), 51);
            end
            if (c == 3) begin
                check("b_done", done_b, 1);
                check("b_valid_end", valid_b, 0);
            end
            if (valid_a) begin
                n++;
                l0 = lane_a(0);
                l1 = lane_a(1);
            end
            c++;
            @(negedge clk);
        end
        check("sweep_done", done_a, 1);
        check("beat_count", n, 128);
        check("last_l0", l0, 8958);
        check("last_l1", l1, 8959);
        check("valid_after_done", valid_a, 0);

        // Back-pressure at idx 4400.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_a(8800, "reach_4400");
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_l0", lane_a(0), 8800);
            check("stall_l1", lane_a(1), 8801);
        end
        ready = 1'b1;
        @(negedge clk);
        check("post_stall_l0", lane_a(0), 8802);
        check("post_stall_l1", lane_a(1), 8803);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Abort mid-sweep at idx 4400.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_a(8800, "reach_4400_b");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", valid_a, 0);
        check("abort_addr", lane_a(0), 8704);

        // Abort coinciding with the final transfer.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_a(8958, "reach_end");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_end_valid", valid_a, 0);
        check("abort_end_done", done_a, 0);

        // Wrap request at the end of the sweep.
        mode_wrap = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_a(8958, "reach_end_wrap");
        @(negedge clk);
        check("wrap_done", done_a, 1);
        check("wrap_valid", valid_a, WRAP_ON ? 1 : 0);
        check("wrap_l0", lane_a(0), 8704);
        check("wrap_l1", lane_a(1), 8705);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        mode_wrap = 1'b0;

        // Asynchronous reset in the middle of a sweep.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_a(8800, "reach_4400_c");
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", valid_a, 0);
        check("async_rst_l0", lane_a(0), 8704);
        check("async_rst_l1", lane_a(1), 8705);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", valid_a, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_l0", lane_a(0), 8704);
        check("restart_valid", valid_a, 1);

        // Random traffic, checked every cycle against the model.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            ready     = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 149) == 0);
            mode_wrap = $urandom_range(0, 1) == 1;
        end
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_sweep_gen.md
ADDR_SWEEP_GEN -- requirements
Module: addr_sweep_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: width of each lane address.
REQ-002 SHALL have parameter LANES, default 2: lane count, a power of two, at least 2; LANE_W = log2(LANES), IDX_W = ADDR_W - LANE_W.
REQ-003 SHALL have parameter IDX_START, default 4352: first sweep index.
REQ-004 SHALL have parameter IDX_END, default 4479: last sweep index, inclusive; IDX_START <= IDX_END < 2^IDX_W.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: begin sweep; sampled in IDLE only.
REQ-008 SHALL have port abort, input, 1: terminate sweep; sampled in RUN only.
REQ-009 SHALL have port mode_wrap, input, 1: 1 = continuous sweep, 0 = one-shot.
REQ-010 SHALL have port ready, input, 1: consumer accepts the current beat.
REQ-011 SHALL have port addr, output, LANES*ADDR_W: lane i occupies bits [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port valid, output, 1: addr holds a beat.
REQ-013 SHALL have port busy, output, 1: state is RUN.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at sweep completion.

Function
REQ-015 SHALL form lane i address as {idx, i[LANE_W-1:0]}: lanes interleave, index shared.
REQ-016 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start; RUN->IDLE on abort or on one-shot completion.
REQ-017 SHALL assert valid = busy = 1 in RUN; in IDLE valid = busy = 0, idx = IDX_START.
REQ-018 SHALL transfer a beat on a cycle with valid && ready; idx and addr SHALL hold while ready = 0.
REQ-019 SHALL on transfer with idx < IDX_END increment idx by 1 the next cycle, no skipping or saturation.
REQ-020 SHALL on transfer with idx == IDX_END and mode_wrap = 1 load idx = IDX_START, stay in RUN, and pulse done for one cycle.
REQ-021 SHALL on transfer with idx == IDX_END and mode_wrap = 0 go to IDLE, drop valid, and pulse done for one cycle.
REQ-022 SHALL make abort take priority over a simultaneous final transfer: go to IDLE, idx = IDX_START, no done pulse.
REQ-023 SHALL ignore start while in RUN, and ignore abort while in IDLE.
REQ-024 SHALL sample mode_wrap only at the IDX_END transfer; changes mid-sweep apply to the current sweep's end.
REQ-025 SHALL register all outputs with no combinational path from inputs; first valid beat appears the cycle after start.
REQ-026 SHALL keep the sweep single-beat when IDX_START == IDX_END.

Reset
REQ-027 SHALL on reset low immediately force state = IDLE, idx = IDX_START, valid = busy = done = 0.
REQ-028 SHALL on reset mid-sweep discard the sweep, issue no done pulse, and restart only on a new start.

Configuration
REQ-029 SHALL compile continuous-sweep support under macro ADDR_SWEEP_WRAP_EN.
REQ-030 SHALL when ADDR_SWEEP_WRAP_EN is undefined keep port mode_wrap but ignore it, so every sweep is one-shot.

Structure
REQ-031 SHALL place the state enum typedef and the default ADDR_W, LANES, IDX_START and IDX_END constants in package addr_sweep_pkg.
REQ-032 SHALL place the index register and its end-of-range compare in sub-module sweep_idx_ctr; the FSM and lane packing SHALL stay in the top module.

Verification (defaults unless stated)
REQ-033 SHALL cover: reset -> addr lanes 8704/8705, valid = 0; start, ready = 1 -> 128 beats 8704/8705 .. 8958/8959, then done pulse and valid = 0.
REQ-034 SHALL cover: ready = 0 for 3 cycles at idx 4400 -> addr holds 8800/8801 for 3 cycles, then 8802/8803.
REQ-035 SHALL cover: mode_wrap = 1 with macro defined -> after 8958/8959 the next beat is 8704/8705, done pulses, valid stays 1; macro undefined -> one-shot.
REQ-036 SHALL cover: abort together with the transfer at idx 4479 -> IDLE, no done; abort at idx 4400 -> valid = 0 next cycle.
REQ-037 SHALL cover: reset low at idx 4400 -> valid = 0 and addr 8704/8705 with no clock edge; a new start restarts at 8704.
REQ-038 SHALL cover: LANES = 4, ADDR_W = 16, IDX_START = 10, IDX_END = 12 -> beats 40..43, 44..47, 48..51, then done.
